io_buffer: RTL and testbench
============================

Name: io_buffer

Overview:
- Ping-pong input/output feature buffer of the NPU core: two banks of 256-bit words.
- An external AXI BRAM-controller port fills or drains one bank while the compute datapath reads the other.
- The internal side gets 1-cycle-latency reads with a valid strobe, zero-padding injection and a write port; bank roles are swapped via i_rsel/i_wsel.

Parameters:
- DW, 256, word width of every data port.
- AW, 12, address width of every address port.
- DEPTH, 4096, words per bank (2**AW).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_iob_extern_en  in  1  grants the external port access to bank ~i_rsel.
- i_iob_bramctl_addr  in  12  external word address.
- i_iob_bramctl_en  in  1  external access enable.
- o_iob_bramctl_rdata  out  256  external read data.
- i_iob_bramctl_we  in  1  external write enable (full word).
- i_iob_bramctl_wdata  in  256  external write data.
- i_iob_raddr  in  12  internal read address.
- i_iob_rd_en  in  1  internal read request.
- i_iob_pad_en  in  1  internal zero-pad request.
- i_iob_waddr  in  12  internal write address.
- i_iob_wr_en  in  1  internal write request.
- i_iob_wdat  in  256  internal write data.
- i_rsel  in  1  bank index used for internal reads.
- i_wsel  in  1  bank index used for internal writes.
- o_mdata  out  256  internal read/pad data.
- o_mdata_vld  out  1  o_mdata valid strobe.

Behaviour:
- Storage: bank0 and bank1, each DEPTH x DW. Contents are not reset and are undefined until written.
- Each bank has port A (write/read, external or internal write) and port B (internal read only).

External access:
- Effective when i_iob_extern_en=1 and i_iob_bramctl_en=1.
- Target is bank ~i_rsel, sampled in the same cycle.
- we=1: the word is written at the edge.
- we=0: the word is read and o_iob_bramctl_rdata is updated one cycle later.
- o_iob_bramctl_rdata holds its value when there is no external read.
- i_iob_extern_en=0: the external port is ignored entirely.

Internal write:
- i_iob_wr_en=1 writes i_iob_wdat at i_iob_waddr into bank i_wsel at the edge.
- Conflict: if an external access targets the same bank (i_wsel == ~i_rsel with extern access active), the external access wins and the internal write is dropped.

Internal read:
- i_iob_rd_en=1 reads bank i_rsel at i_iob_raddr.
- o_mdata equals that word on the next cycle, with o_mdata_vld=1 for exactly that cycle.
- Read-first: a read of a location written in the same cycle returns the old contents.

Pad:
- i_iob_pad_en=1 gives o_mdata=0 and o_mdata_vld=1 on the next cycle.
- pad_en and rd_en together: pad wins and no memory read occurs.

Idle:
- o_mdata_vld=0 the cycle after neither rd_en nor pad_en.
- o_mdata holds its last value.

Latency:
- Fixed 1 cycle for all reads and pads; back-to-back requests every cycle give continuous vld.

Bank swap:
- i_rsel/i_wsel may change on any cycle.
- A change takes effect for requests sampled in that cycle; in-flight data is unaffected.

Reset (async, any time):
- o_mdata=0, o_mdata_vld=0, o_iob_bramctl_rdata=0 immediately.
- The pending read pipeline is flushed; memory contents are kept.

Decomposition:
- Shared package npu_iob_pkg holds IOB_DW=256, IOB_AW=12, IOB_DEPTH.
- One sub-module, iob_bank_ram: simple dual-port RAM, read-first.
  - Port A: write, or registered read.
  - Port B: registered read.
  - Instantiated twice.
- Top level contains only port muxing, conflict priority, and the pad/valid register.

Test Plan:
1. Reset, then i_rsel=1, extern_en=1, external writes to bank0: addr1=0xA1, addr2=0xA2, addr3=0xA3. Extern reads of addr2 -> rdata=0xA2 one cycle later.
2. i_rsel=0, pad_en pulse 1 cycle, then rd_en with raddr 1,2,3 on consecutive cycles, then idle:
   - o_mdata: 0 then 0xA1, 0xA2, 0xA3;
   - o_mdata_vld high for 4 consecutive cycles, then 0.
3. i_wsel=1, wr_en writes 0xB5 at waddr 5. Then i_rsel=1, rd_en raddr 5 -> o_mdata=0xB5, vld=1 after one cycle.
4. Conflict: i_rsel=0, i_wsel=1, extern_en=1, external we at addr 7 with 0xE7 and internal wr_en at waddr 7 with 0xD7 in the same cycle. Internal read of bank1 addr 7 -> 0xE7.
5. Simultaneous rd_en (raddr 1) and pad_en -> o_mdata=0, vld=1. Read-first: same-cycle write and read to one address returns the old value.
6. Assert rst mid-stream during back-to-back reads -> o_mdata_vld=0 and o_mdata=0 immediately. After release, the data written earlier is still readable.

Source files
------------

// File: rtl/npu_iob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_iob_pkg
//  Description : Shared sizing constants for the NPU ping-pong I/O buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_iob_pkg;

    localparam int IOB_DW    = 256;
    localparam int IOB_AW    = 12;
    localparam int IOB_DEPTH = 1 << IOB_AW;

endpackage : npu_iob_pkg
`default_nettype wire

// File: rtl/iob_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : iob_bank_ram
//  Description : Simple dual-port bank RAM, read-first. Port A writes or does a
//                registered read; port B is a registered read only. Read data
//                registers update only on a read and hold otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_bank_ram
    import npu_iob_pkg::*;
#(
    parameter int DW    = IOB_DW,
    parameter int AW    = IOB_AW,
    parameter int DEPTH = IOB_DEPTH
) (
    input  logic          clk,
    input  logic          i_a_en,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic [DW-1:0] o_a_rdata,
    input  logic          i_b_en,
    input  logic [AW-1:0] i_b_addr,
    output logic [DW-1:0] o_b_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;

    // Port A: write the word, or capture the old contents on a read
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            if (i_a_we) begin
                r_mem[i_a_addr] <= i_a_wdata;
            end else begin
                r_a_rdata <= r_mem[i_a_addr];
            end
        end
    end

    // Port B: registered read; sees pre-write contents of a same-cycle write
    always_ff @(posedge clk) begin
        if (i_b_en) begin
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule : iob_bank_ram
`default_nettype wire

// File: rtl/io_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : io_buffer
//  Description : Ping-pong feature buffer. The external BRAM-controller port
//                owns bank ~i_rsel; the datapath reads bank i_rsel and writes
//                bank i_wsel. External access beats a colliding internal
//                write. Pad requests return zero with the same 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_buffer
    import npu_iob_pkg::*;
#(
    parameter int DW    = IOB_DW,
    parameter int AW    = IOB_AW,
    parameter int DEPTH = IOB_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_iob_extern_en,
    input  logic [AW-1:0] i_iob_bramctl_addr,
    input  logic          i_iob_bramctl_en,
    output logic [DW-1:0] o_iob_bramctl_rdata,
    input  logic          i_iob_bramctl_we,
    input  logic [DW-1:0] i_iob_bramctl_wdata,
    input  logic [AW-1:0] i_iob_raddr,
    input  logic          i_iob_rd_en,
    input  logic          i_iob_pad_en,
    input  logic [AW-1:0] i_iob_waddr,
    input  logic          i_iob_wr_en,
    input  logic [DW-1:0] i_iob_wdat,
    input  logic          i_rsel,
    input  logic          i_wsel,
    output logic [DW-1:0] o_mdata,
    output logic          o_mdata_vld
);

    logic          w_ext_act;
    logic          w_ext_bank;
    logic          w_ext_rd;
    logic [DW-1:0] w_a_rdata [2];
    logic [DW-1:0] w_b_rdata [2];

    logic          r_mdata_vld;
    logic          r_mdata_pad;
    logic          r_mdata_bank;
    logic          r_ext_vld;
    logic          r_ext_bank;

    assign w_ext_act  = i_iob_extern_en & i_iob_bramctl_en;
    assign w_ext_bank = ~i_rsel;
    assign w_ext_rd   = w_ext_act & ~i_iob_bramctl_we;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic c_bank_idx = 1'(gi);

        logic          w_a_en;
        logic          w_a_we;
        logic [AW-1:0] w_a_addr;
        logic [DW-1:0] w_a_wdata;
        logic          w_b_en;

        // Port A owner: external access first, else the internal write
        always_comb begin
            w_a_en    = 1'b0;
            w_a_we    = 1'b0;
            w_a_addr  = '0;
            w_a_wdata = '0;
            if (w_ext_act && (w_ext_bank == c_bank_idx)) begin
                w_a_en    = 1'b1;
                w_a_we    = i_iob_bramctl_we;
                w_a_addr  = i_iob_bramctl_addr;
                w_a_wdata = i_iob_bramctl_wdata;
            end else if (i_iob_wr_en && (i_wsel == c_bank_idx)) begin
                w_a_en    = 1'b1;
                w_a_we    = 1'b1;
                w_a_addr  = i_iob_waddr;
                w_a_wdata = i_iob_wdat;
            end
        end

        // A pad request suppresses the memory read entirely
        assign w_b_en = i_iob_rd_en & ~i_iob_pad_en & (i_rsel == c_bank_idx);

        iob_bank_ram #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk       (clk),
            .i_a_en    (w_a_en),
            .i_a_we    (w_a_we),
            .i_a_addr  (w_a_addr),
            .i_a_wdata (w_a_wdata),
            .o_a_rdata (w_a_rdata[gi]),
            .i_b_en    (w_b_en),
            .i_b_addr  (i_iob_raddr),
            .o_b_rdata (w_b_rdata[gi])
        );
    end

    // Internal response tracking: valid strobe plus which source drives o_mdata.
    // The pad flag is set on reset so the output reads as zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdata_vld  <= 1'b0;
            r_mdata_pad  <= 1'b1;
            r_mdata_bank <= 1'b0;
        end else begin
            r_mdata_vld <= i_iob_rd_en | i_iob_pad_en;
            if (i_iob_pad_en) begin
                r_mdata_pad <= 1'b1;
            end else if (i_iob_rd_en) begin
                r_mdata_pad  <= 1'b0;
                r_mdata_bank <= i_rsel;
            end
        end
    end

    // External read tracking: which bank's port A holds the last external read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_vld  <= 1'b0;
            r_ext_bank <= 1'b0;
        end else if (w_ext_rd) begin
            r_ext_vld  <= 1'b1;
            r_ext_bank <= w_ext_bank;
        end
    end

    assign o_mdata_vld         = r_mdata_vld;
    assign o_mdata             = r_mdata_pad ? '0 : w_b_rdata[r_mdata_bank];
    assign o_iob_bramctl_rdata = r_ext_vld ? w_a_rdata[r_ext_bank] : '0;

endmodule : io_buffer
`default_nettype wire

// File: tb/tb_io_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_buffer
//  Description : Directed bench for io_buffer. Expected internal responses are
//                queued at issue time and popped by a monitor on every valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_buffer;

    localparam int DW = 256;
    localparam int AW = 12;

    typedef logic [DW-1:0] word_t;

    logic          clk;
    logic          rst;
    logic          i_iob_extern_en;
    logic [AW-1:0] i_iob_bramctl_addr;
    logic          i_iob_bramctl_en;
    logic [DW-1:0] o_iob_bramctl_rdata;
    logic          i_iob_bramctl_we;
    logic [DW-1:0] i_iob_bramctl_wdata;
    logic [AW-1:0] i_iob_raddr;
    logic          i_iob_rd_en;
    logic          i_iob_pad_en;
    logic [AW-1:0] i_iob_waddr;
    logic          i_iob_wr_en;
    logic [DW-1:0] i_iob_wdat;
    logic          i_rsel;
    logic          i_wsel;
    logic [DW-1:0] o_mdata;
    logic          o_mdata_vld;

    int    checks;
    int    failures;
    word_t exp_q [$];

    io_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_iob_extern_en     (i_iob_extern_en),
        .i_iob_bramctl_addr  (i_iob_bramctl_addr),
        .i_iob_bramctl_en    (i_iob_bramctl_en),
        .o_iob_bramctl_rdata (o_iob_bramctl_rdata),
        .i_iob_bramctl_we    (i_iob_bramctl_we),
        .i_iob_bramctl_wdata (i_iob_bramctl_wdata),
        .i_iob_raddr         (i_iob_raddr),
        .i_iob_rd_en         (i_iob_rd_en),
        .i_iob_pad_en        (i_iob_pad_en),
        .i_iob_waddr         (i_iob_waddr),
        .i_iob_wr_en         (i_iob_wr_en),
        .i_iob_wdat          (i_iob_wdat),
        .i_rsel              (i_rsel),
        .i_wsel              (i_wsel),
        .o_mdata             (o_mdata),
        .o_mdata_vld         (o_mdata_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and sampled at the next
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle();
        i_iob_extern_en  = 1'b0;
        i_iob_bramctl_en = 1'b0;
        i_iob_bramctl_we = 1'b0;
        i_iob_rd_en      = 1'b0;
        i_iob_pad_en     = 1'b0;
        i_iob_wr_en      = 1'b0;
    endtask

    // Monitor: every valid cycle consumes exactly one queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_mdata_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vld: got vld=1 data=%h expected no response", o_mdata);
                end else begin
                    chk("mdata", o_mdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        all_idle();
        i_iob_bramctl_addr  = '0;
        i_iob_bramctl_wdata = '0;
        i_iob_raddr         = '0;
        i_iob_waddr         = '0;
        i_iob_wdat          = '0;
        i_rsel              = 1'b0;
        i_wsel              = 1'b0;

        repeat (3) cyc();
        chk("reset_mdata", o_mdata, '0);
        chk("reset_vld", word_t'(o_mdata_vld), '0);
        chk("reset_rdata", o_iob_bramctl_rdata, '0);
        rst = 1'b0;
        cyc();

        // 1: external writes into bank0 (rsel=1), ignored write, external reads
        i_rsel = 1'b1;
        i_iob_extern_en = 1'b1; i_iob_bramctl_en = 1'b1; i_iob_bramctl_we = 1'b1;
        i_iob_bramctl_addr = 12'd1; i_iob_bramctl_wdata = word_t'(8'hA1); cyc();
        i_iob_bramctl_addr = 12'd2; i_iob_bramctl_wdata = word_t'(8'hA2); cyc();
        i_iob_bramctl_addr = 12'd3; i_iob_bramctl_wdata = word_t'(8'hA3); cyc();
        i_iob_extern_en = 1'b0;
        i_iob_bramctl_addr = 12'd1; i_iob_bramctl_wdata = word_t'(8'hFF); cyc();
        i_iob_extern_en = 1'b1; i_iob_bramctl_we = 1'b0;
        i_iob_bramctl_addr = 12'd2; cyc();
        chk("ext_rd_a2", o_iob_bramctl_rdata, word_t'(8'hA2));
        i_iob_bramctl_en = 1'b0; cyc();
        chk("ext_rd_hold", o_iob_bramctl_rdata, word_t'(8'hA2));
        i_iob_bramctl_en = 1'b1; i_iob_bramctl_addr = 12'd1; cyc();
        chk("ext_ignored_wr", o_iob_bramctl_rdata, word_t'(8'hA1));
        all_idle();

        // 2: pad then three back-to-back reads of bank0, then idle
        i_rsel = 1'b0;
        i_iob_pad_en = 1'b1; exp_q.push_back('0); cyc();
        i_iob_pad_en = 1'b0; i_iob_rd_en = 1'b1;
        i_iob_raddr = 12'd1; exp_q.push_back(word_t'(8'hA1)); cyc();
        i_iob_raddr = 12'd2; exp_q.push_back(word_t'(8'hA2)); cyc();
        i_iob_raddr = 12'd3; exp_q.push_back(word_t'(8'hA3)); cyc();
        i_iob_rd_en = 1'b0; cyc();
        chk("idle_vld", word_t'(o_mdata_vld), '0);
        chk("idle_hold", o_mdata, word_t'(8'hA3));

        // 3: internal write into bank1, read it back
        i_wsel = 1'b1; i_iob_wr_en = 1'b1;
        i_iob_waddr = 12'd5; i_iob_wdat = word_t'(8'hB5); cyc();
        i_iob_wr_en = 1'b0;
        i_rsel = 1'b1; i_iob_rd_en = 1'b1;
        i_iob_raddr = 12'd5; exp_q.push_back(word_t'(8'hB5)); cyc();
        i_iob_rd_en = 1'b0; cyc();

        // 4: external and internal write collide on bank1 addr 7
        i_rsel = 1'b0; i_wsel = 1'b1;
        i_iob_extern_en = 1'b1; i_iob_bramctl_en = 1'b1; i_iob_bramctl_we = 1'b1;
        i_iob_bramctl_addr = 12'd7; i_iob_bramctl_wdata = word_t'(8'hE7);
        i_iob_wr_en = 1'b1; i_iob_waddr = 12'd7; i_iob_wdat = word_t'(8'hD7); cyc();
        all_idle();
        i_rsel = 1'b1; i_iob_rd_en = 1'b1;
        i_iob_raddr = 12'd7; exp_q.push_back(word_t'(8'hE7)); cyc();
        i_iob_rd_en = 1'b0; cyc();

        // 5: pad wins over read; read-first on same-cycle write/read
        i_rsel = 1'b0; i_iob_rd_en = 1'b1; i_iob_pad_en = 1'b1;
        i_iob_raddr = 12'd1; exp_q.push_back('0); cyc();
        i_iob_pad_en = 1'b0;
        i_wsel = 1'b0; i_iob_wr_en = 1'b1;
        i_iob_waddr = 12'd2; i_iob_wdat = word_t'(8'hC2);
        i_iob_raddr = 12'd2; exp_q.push_back(word_t'(8'hA2)); cyc();
        i_iob_wr_en = 1'b0;
        i_iob_raddr = 12'd2; exp_q.push_back(word_t'(8'hC2)); cyc();
        i_iob_rd_en = 1'b0; cyc();

        // 6: async reset during back-to-back reads
        i_rsel = 1'b0; i_iob_rd_en = 1'b1;
        i_iob_raddr = 12'd1; exp_q.push_back(word_t'(8'hA1)); cyc();
        i_iob_raddr = 12'd2; exp_q.push_back(word_t'(8'hC2)); cyc();
        i_iob_raddr = 12'd3; exp_q.push_back(word_t'(8'hA3));
        #2;
        rst = 1'b1;
        i_iob_rd_en = 1'b0;
        #1;
        chk("rst_async_vld", word_t'(o_mdata_vld), '0);
        chk("rst_async_mdata", o_mdata, '0);
        chk("rst_async_rdata", o_iob_bramctl_rdata, '0);
        exp_q.delete();
        cyc();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        i_iob_rd_en = 1'b1;
        i_iob_raddr = 12'd1; exp_q.push_back(word_t'(8'hA1)); cyc();
        i_rsel = 1'b1;
        i_iob_raddr = 12'd5; exp_q.push_back(word_t'(8'hB5)); cyc();
        i_rsel = 1'b0;
        i_iob_raddr = 12'd3; exp_q.push_back(word_t'(8'hA3)); cyc();
        i_iob_rd_en = 1'b0;
        repeat (3) cyc();
        chk("post_vld", word_t'(o_mdata_vld), '0);
        chk("queue_drained", word_t'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_io_buffer
`default_nettype wire
